// File: rtl/magnitude_comparator_seq.sv
// Sequential magnitude comparator: scans SLICE-bit slices MSB-first, one per clock,
// stops at the first differing slice and falls back to 74LS85-style cascade inputs on full equality.
//
// state  | meaning
// IDLE   | waiting for start; result registers hold the last decision
// SCAN   | comparing slice r_idx; r_idx counts down to 0
module magnitude_comparator_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             igt,
  input  logic             ilt,
  input  logic             ieq,
  output logic             busy,
  output logic             done,
  output logic             ogt,
  output logic             olt,
  output logic             oeq
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NSLICE - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_cas;
  logic             r_sgn;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic             r_done;
  logic [2:0]       r_res;
  logic [SLICE-1:0] w_sa, w_sb;
  logic             w_decide;
  logic [2:0]       w_res;
  logic [2:0]       w_cas_res;

  // Inverting the sign bit of the top slice maps two's complement onto unsigned order.
  always_comb begin
    w_sa = r_a[int'(r_idx)*SLICE +: SLICE];
    w_sb = r_b[int'(r_idx)*SLICE +: SLICE];
    if (r_sgn && (r_idx == TOP_IDX)) begin
      w_sa[SLICE-1] = ~w_sa[SLICE-1];
      w_sb[SLICE-1] = ~w_sb[SLICE-1];
    end
  end

  always_comb begin
    w_cas_res = 3'b001;
    if (!r_cas[0]) begin
      case (r_cas[2:1])
        2'b10:   w_cas_res = 3'b100;
        2'b01:   w_cas_res = 3'b010;
        2'b11:   w_cas_res = 3'b000;
        default: w_cas_res = 3'b110;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_decide    = 1'b0;
    w_res       = 3'b000;
    if (r_state == S_SCAN) begin
      if (w_sa > w_sb) begin
        w_decide = 1'b1;
        w_res    = 3'b100;
      end else if (w_sa < w_sb) begin
        w_decide = 1'b1;
        w_res    = 3'b010;
      end else if (r_idx != '0) begin
        w_idx_nxt = r_idx - 1'b1;
      end else begin
        w_decide = 1'b1;
        w_res    = w_cas_res;
      end
      if (w_decide) w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cas   <= '0;
      r_sgn   <= 1'b0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_res   <= 3'b000;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_state <= S_SCAN;
          r_a     <= a;
          r_b     <= b;
          r_cas   <= {igt, ilt, ieq};
          r_sgn   <= signed_mode;
          r_idx   <= TOP_IDX;
        end
      end else begin
        r_state <= w_state_nxt;
        r_idx   <= w_idx_nxt;
        if (w_decide) begin
          r_res  <= w_res;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == S_SCAN);
  assign done = r_done;
  assign ogt  = r_res[2];
  assign olt  = r_res[1];
  assign oeq  = r_res[0];

endmodule

// File: tb/tb_magnitude_comparator_seq.sv
// Directed bench for magnitude_comparator_seq: 16/4 default, 8/8 degenerate and 12/4 randomised instances.
module tb_magnitude_comparator_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  st = 3'b000;
  logic        sgn = 1'b0, igt = 1'b0, ilt = 1'b0, ieq = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [2:0]  busy_v, done_v;
  logic [2:0]  res0, res1, res2;
  logic [2:0]  last_res [3];
  int          n_cmp = 0, n_err = 0, cyc = 0, e0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  magnitude_comparator_seq #(.WIDTH(16), .SLICE(4)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .signed_mode(sgn), .a(a), .b(b),
    .igt(igt), .ilt(ilt), .ieq(ieq), .busy(busy_v[0]), .done(done_v[0]),
    .ogt(res0[2]), .olt(res0[1]), .oeq(res0[0]));

  magnitude_comparator_seq #(.WIDTH(8), .SLICE(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .signed_mode(sgn), .a(a[7:0]), .b(b[7:0]),
    .igt(igt), .ilt(ilt), .ieq(ieq), .busy(busy_v[1]), .done(done_v[1]),
    .ogt(res1[2]), .olt(res1[1]), .oeq(res1[0]));

  magnitude_comparator_seq #(.WIDTH(12), .SLICE(4)) u_d12 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .signed_mode(sgn), .a(a[11:0]), .b(b[11:0]),
    .igt(igt), .ilt(ilt), .ieq(ieq), .busy(busy_v[2]), .done(done_v[2]),
    .ogt(res2[2]), .olt(res2[1]), .oeq(res2[0]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] get_res(input int sel);
    case (sel)
      0:       return res0;
      1:       return res1;
      default: return res2;
    endcase
  endfunction

  function automatic logic [2:0] cas_ref(input logic [2:0] c);
    if (c[0]) return 3'b001;
    case (c[2:1])
      2'b10:   return 3'b100;
      2'b01:   return 3'b010;
      2'b11:   return 3'b000;
      default: return 3'b110;
    endcase
  endfunction

  task automatic launch(input int sel, input logic [15:0] va, input logic [15:0] vb,
                        input logic vs, input logic [2:0] vc);
    a = va; b = vb; sgn = vs; {igt, ilt, ieq} = vc;
    st[sel] = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    st = 3'b000;
  endtask

  task automatic wait_done(input int sel, input logic [2:0] exp_res, input int exp_lat,
                           input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0 || cyc != e0) begin
        if (done_v[sel]) begin got = 1'b1; break; end
        chk({tag, "_busy"}, 32'(busy_v[sel]), 32'd1);
        chk({tag, "_hold"}, 32'(get_res(sel)), 32'(last_res[sel]));
      end
      @(posedge clk); #1;
    end
    chk({tag, "_timeout"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_lat"}, 32'(cyc - e0), 32'(exp_lat));
      chk({tag, "_res"}, 32'(get_res(sel)), 32'(exp_res));
      chk({tag, "_busyfall"}, 32'(busy_v[sel]), 32'd0);
      last_res[sel] = exp_res;
    end
  endtask

  task automatic no_done(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk({tag, "_nodone"}, 32'(done_v), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  cas_tab [6];
    logic [2:0]  exp_tab [6];
    logic [11:0] ra, rb;
    logic [2:0]  rc, er;
    logic        rs;
    int          lead, lat;

    cas_tab = '{3'b100, 3'b010, 3'b001, 3'b011, 3'b110, 3'b000};
    exp_tab = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b000, 3'b110};
    for (int i = 0; i < 3; i++) last_res[i] = 3'b000;

    #1;
    chk("rst_busy", 32'(busy_v), 32'd0);
    chk("rst_done", 32'(done_v), 32'd0);
    chk("rst_res", 32'({res0, res1, res2}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(0, 16'h1234, 16'h1235, 1'b0, 3'b001);
    chk("basic_busy_e0", 32'(busy_v[0]), 32'd1);
    wait_done(0, 3'b010, 4, "basic");

    launch(0, 16'h8000, 16'h7FFF, 1'b0, 3'b001);
    wait_done(0, 3'b100, 1, "uns_8000");
    launch(0, 16'h8000, 16'h7FFF, 1'b1, 3'b001);
    wait_done(0, 3'b010, 1, "sgn_8000");
    launch(0, 16'hFFFF, 16'h0001, 1'b1, 3'b001);
    wait_done(0, 3'b010, 1, "sgn_ffff");

    for (int i = 0; i < 6; i++) begin
      launch(0, 16'hABCD, 16'hABCD, 1'b0, cas_tab[i]);
      wait_done(0, exp_tab[i], 4, $sformatf("cas%0d", i));
    end

    // start pulse mid-scan must be dropped, not queued
    launch(0, 16'h1234, 16'h1234, 1'b0, 3'b001);
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'h0000; {igt, ilt, ieq} = 3'b100; st[0] = 1'b1;
    @(posedge clk); #1;
    st = 3'b000;
    wait_done(0, 3'b001, 4, "ign");
    no_done(6, "ign");
    chk("ign_busy", 32'(busy_v[0]), 32'd0);

    launch(0, 16'h1111, 16'h1111, 1'b0, 3'b010);
    wait_done(0, 3'b010, 4, "b2b_first");
    launch(0, 16'h0F00, 16'h0E00, 1'b0, 3'b001);
    wait_done(0, 3'b100, 2, "b2b_second");

    launch(0, 16'h5555, 16'h5555, 1'b0, 3'b001);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_v), 32'd0);
    chk("mid_rst_done", 32'(done_v), 32'd0);
    chk("mid_rst_res", 32'(res0), 32'd0);
    for (int i = 0; i < 3; i++) last_res[i] = 3'b000;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    no_done(6, "post_rst");
    launch(0, 16'h0001, 16'h0002, 1'b0, 3'b001);
    wait_done(0, 3'b010, 4, "post_rst");

    launch(1, 16'h007F, 16'h0080, 1'b0, 3'b001);
    wait_done(1, 3'b010, 1, "w8_uns");
    launch(1, 16'h007F, 16'h0080, 1'b1, 3'b001);
    wait_done(1, 3'b100, 1, "w8_sgn");

    for (int i = 0; i < 12; i++) begin
      ra = 12'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 12'($urandom);
        1:       rb = ra ^ (12'd1 << $urandom_range(0, 11));
        default: rb = ra;
      endcase
      rs = 1'($urandom);
      rc = 3'($urandom);
      if (ra == rb)                          er = cas_ref(rc);
      else if (rs && ($signed(ra) > $signed(rb))) er = 3'b100;
      else if (rs)                           er = 3'b010;
      else if (ra > rb)                      er = 3'b100;
      else                                   er = 3'b010;
      lead = 0;
      for (int s = 2; s >= 0; s--) begin
        if (ra[s*4 +: 4] != rb[s*4 +: 4]) break;
        lead++;
      end
      lat = (lead > 2) ? 3 : lead + 1;
      launch(2, {4'h0, ra}, {4'h0, rb}, rs, rc);
      wait_done(2, er, lat, $sformatf("w12_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/magnitude_comparator_seq.md
# magnitude_comparator_seq

Parametrised sequential magnitude comparator: the multi-slice successor to the 4-bit 74LS85-style comparator in the 74LSXX library. It captures two WIDTH-bit operands, an optional signed mode and 74LS85-compatible cascade inputs on a start strobe. It then scans SLICE-bit slices MSB-first, one slice per clock, terminating early on the first differing slice. The result is reported with a one-cycle done pulse. It serves clock/alarm time-match and limit checks where operands exceed 4 bits and a multi-cycle result is acceptable.

## Interface
- WIDTH, 16, operand width in bits; must be a positive multiple of SLICE.
- SLICE, 4, bits compared per clock. NSLICE = WIDTH/SLICE.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- signed_mode  in  1  1: operands are two's complement; 0: unsigned.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- igt, ilt, ieq  in  1 each  cascade inputs from a less-significant stage.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse; result valid and updated.
- ogt, olt, oeq  out  1 each  registered result; held until the next done.

## Operation
- States: IDLE, SCAN.
- IDLE: busy=0. start=1 at an edge loads the following registers and enters SCAN:
  - a_r←a, b_r←b.
  - cas_r←{igt,ilt,ieq}.
  - sgn_r←signed_mode.
  - idx←NSLICE-1.
- SCAN: each cycle compares slice idx of a_r and b_r as unsigned SLICE-bit values.
  - The top slice (idx=NSLICE-1) has its MSB inverted in both operands when sgn_r=1. This yields a correct two's-complement order.
- Slice A > B: result {ogt,olt,oeq}=100; decision.
- Slice A < B: result 010; decision.
- Slices equal and idx>0: idx←idx-1; remain in SCAN.
- Slices equal and idx=0: result from cas_r; decision.
  - ieq=1, any igt/ilt → 001.
  - 100 → 100.
  - 010 → 010.
  - 110 → 000.
  - 000 → 110.
- Decision edge: ogt/olt/oeq←result, done←1, state←IDLE.
- start while busy=1 is ignored; it is not queued.
- Inputs a, b, igt, ilt, ieq and signed_mode are don't-care except at the accepting edge.
- rst_n low at any time, including mid-SCAN, does all of the following immediately:
  - Forces IDLE.
  - Sets busy=0, done=0, ogt=olt=oeq=0.
  - Discards the pending comparison; no done is issued for it.

## Timing
- Reset values: busy=0, done=0, ogt=0, olt=0, oeq=0, state IDLE.
- Accept edge E0: start=1 and busy=0. busy=1 from E0.
- Let j be the number of leading equal slices, 0..NSLICE-1, or NSLICE-1 when all slices are equal.
  - The decision edge is E0+(j+1) clocks.
  - Latency range is 1..NSLICE clocks.
- At the decision edge, all of the following happen together:
  - busy falls.
  - done rises for exactly one cycle.
  - The outputs update.
- ogt/olt/oeq never change except at a decision edge or reset.
- Back-to-back: start=1 during the done cycle is accepted (state is IDLE). A new comparison can therefore start every j+2 cycles.
- WIDTH=SLICE degenerates to a fixed 1-cycle latency.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Defaults (WIDTH=16, SLICE=4), unsigned.
  - Stimulus: a=0x1234, b=0x1235, cascade 001, start at E0.
  - Response: busy high for 4 cycles; done at E0+4; {ogt,olt,oeq}=010.
- Early exit and signed mode.
  - Stimulus: a=0x8000, b=0x7FFF, unsigned.
  - Response: 100 at E0+1.
  - Repeat with signed_mode=1: 010 at E0+1.
  - Stimulus: a=0xFFFF, b=0x0001, signed.
  - Response: 010.
- Cascade decode.
  - Stimulus: a=b=0xABCD with cascade 100, 010, 001, 011, 110, 000.
  - Response: results 100, 010, 001, 001, 000, 110 respectively, each done at E0+4.
- Handshake.
  - Stimulus: start pulsed at E0+2 of a busy scan.
  - Response: ignored; exactly one done.
  - Stimulus: start held during the done cycle with new operands a=0x0F00, b=0x0E00.
  - Response: accepted; done at the accept edge+2 with 100.
- Reset mid-scan.
  - Stimulus: a=b=0x5555, start; drop rst_n at E0+2.
  - Response: busy, done, ogt, olt, oeq=0 asynchronously; no done after release.
  - Stimulus: next start with a=0x0001, b=0x0002.
  - Response: 010 at +4.
- Parameter sweep.
  - Stimulus: WIDTH=8, SLICE=8; a=0x7F, b=0x80.
  - Response: unsigned 010, signed 100, both at latency 1.
  - Stimulus: WIDTH=12, SLICE=4; randomised operands.
  - Response: results match a reference compare; latency equals the leading-equal-slice count + 1.
